// File: rtl/qsfp_bw_check_if.sv
// AXI-Stream style beat interface for the QSFP bandwidth checker.
// The master drives data/valid/last; the slave (checker) drives ready.
interface qsfp_bw_check_if;
    logic [255:0] IN_AXIS_TDATA;
    logic         IN_AXIS_TVALID;
    logic         IN_AXIS_TLAST;
    logic         IN_AXIS_TREADY;

    modport master (output IN_AXIS_TDATA, output IN_AXIS_TVALID, output IN_AXIS_TLAST,
                    input  IN_AXIS_TREADY);
    modport slave  (input  IN_AXIS_TDATA, input  IN_AXIS_TVALID, input  IN_AXIS_TLAST,
                    output IN_AXIS_TREADY);
endinterface

// File: rtl/qsfp_bw_check.sv
// Receive-side QSFP bandwidth/integrity checker: times blocks of BLOCK_BEATS beats and checks
// the sender count pattern. Define QSFP_BW_THROTTLE_EN for LFSR-driven pseudo-random backpressure.
module qsfp_bw_check #(
    parameter logic [31:0] BLOCK_BEATS = 32'h0200_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    qsfp_bw_check_if.slave        in_axis,
    output logic [63:0]           rcv_time,
    output logic [31:0]           block_count,
    output logic [31:0]           error_count,
    output logic [31:0]           tlast_count,
    output logic                  busy,
    output logic                  done
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q;
    logic [63:0] cycle_q;
    logic [63:0] start_q;
    logic [63:0] prev_q;
    logic        have_prev_q;
    logic [31:0] beat_cnt_q;
    logic [63:0] rcv_time_q;
    logic [31:0] block_cnt_q;
    logic [31:0] err_cnt_q;
    logic [31:0] err_cnt_d;
    logic [31:0] tlast_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        tready_q;

    logic        accept;
    logic        pattern_err;

    assign accept      = in_axis.IN_AXIS_TVALID && tready_q;
    // Upper lanes must be zero and the count must strictly increase, across block boundaries.
    assign pattern_err = (|in_axis.IN_AXIS_TDATA[255:64]) ||
                         (have_prev_q && (in_axis.IN_AXIS_TDATA[63:0] <= prev_q));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && pattern_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

`ifdef QSFP_BW_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q   <= 16'hACE1;
            tready_q <= 1'b0;
        end else begin
            lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
            tready_q <= (lfsr_q[1:0] != 2'b00);
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q     <= 64'd0;
            prev_q      <= 64'd0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= 32'd0;
            tlast_cnt_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_q + 64'd1;
            err_cnt_q <= err_cnt_d;
            if (accept) begin
                prev_q      <= in_axis.IN_AXIS_TDATA[63:0];
                have_prev_q <= 1'b1;
                if (in_axis.IN_AXIS_TLAST) begin
                    tlast_cnt_q <= tlast_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 64'd0;
            beat_cnt_q  <= 32'd0;
            rcv_time_q  <= 64'd0;
            block_cnt_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        start_q    <= cycle_q;
                        beat_cnt_q <= 32'd1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 32'd1;
                        // beat_cnt_q counts beats already taken, so this beat closes the block.
                        if (beat_cnt_q == BLOCK_BEATS - 32'd1) begin
                            rcv_time_q  <= cycle_q - start_q;
                            block_cnt_q <= block_cnt_q + 32'd1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_axis.IN_AXIS_TREADY = tready_q;
    assign rcv_time    = rcv_time_q;
    assign block_count = block_cnt_q;
    assign error_count = err_cnt_q;
    assign tlast_count = tlast_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_qsfp_bw_check.sv
// Scoreboard bench for qsfp_bw_check with BLOCK_BEATS=4: stimulus pushes expected block
// results, a monitor pops them on every done pulse.
module tb_qsfp_bw_check;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rcv_time;
    logic [31:0] block_count, error_count, tlast_count;
    logic        busy, done;

    qsfp_bw_check_if bus ();

    qsfp_bw_check #(.BLOCK_BEATS(32'd4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_axis     (bus),
        .rcv_time    (rcv_time),
        .block_count (block_count),
        .error_count (error_count),
        .tlast_count (tlast_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] rcv;
        bit          rcv_exact;
        logic [31:0] blocks;
        logic [31:0] errs;
    } exp_t;

    exp_t        sb[$];
    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    longint      tb_cyc     = 0;
    longint      done_times[$];
    bit          meas = 0;
    int          meas_cyc = 0;
    int          meas_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic chk_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
        assert_cnt++;
        if (act < lo || act > hi) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d in %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(posedge clock) tb_cyc++;

    // Monitor: each done pulse must match the oldest expected block result.
    always @(negedge clock) begin
        if (!reset && done) begin
            exp_t e;
            done_times.push_back(tb_cyc);
            if (sb.size() == 0) begin
                assert_cnt++;
                fail_cnt++;
                $display("FAIL unexpected_done: got block_count %0d expected no done", block_count);
            end else begin
                e = sb.pop_front();
                if (e.rcv_exact) chk("blk_rcv_time", rcv_time, e.rcv);
                else             chk_range("blk_rcv_time_min", rcv_time, e.rcv, 64'hFFFF_FFFF);
                chk("blk_block_count", {32'd0, block_count}, {32'd0, e.blocks});
                chk("blk_error_count", {32'd0, error_count}, {32'd0, e.errs});
            end
        end
        if (meas) begin
            meas_cyc++;
            if (bus.IN_AXIS_TREADY) meas_rdy++;
        end
    end

    task automatic push_exp(input logic [63:0] rcv, input bit exact,
                            input logic [31:0] blocks, input logic [31:0] errs);
        exp_t e;
        e.rcv = rcv; e.rcv_exact = exact; e.blocks = blocks; e.errs = errs;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_beat(input logic [255:0] d, input logic l);
        int n = 0;
        bus.IN_AXIS_TDATA  = d;
        bus.IN_AXIS_TVALID = 1'b1;
        bus.IN_AXIS_TLAST  = l;
        while (!bus.IN_AXIS_TREADY && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL tready_timeout: got tready 0 for %0d cycles expected 1", n);
        end
        @(negedge clock);
        bus.IN_AXIS_TVALID = 1'b0;
        bus.IN_AXIS_TLAST  = 1'b0;
    endtask

    task automatic send_cnt(input logic [63:0] c, input logic l);
        logic [255:0] d;
        d = {192'd0, c};
        send_beat(d, l);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain(input string name);
        idle(2);
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset(input int n, input bit check_vals);
        @(negedge clock);
        reset = 1'b1;
        bus.IN_AXIS_TVALID = 1'b0;
        bus.IN_AXIS_TLAST  = 1'b0;
        idle(n);
        if (check_vals) begin
            chk("rst_tready", {63'd0, bus.IN_AXIS_TREADY}, 0);
            chk("rst_rcv_time", rcv_time, 0);
            chk("rst_block_count", {32'd0, block_count}, 0);
            chk("rst_error_count", {32'd0, error_count}, 0);
            chk("rst_tlast_count", {32'd0, tlast_count}, 0);
            chk("rst_busy_done", {62'd0, busy, done}, 0);
        end
        sb.delete();
        done_times.delete();
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [255:0] bad;
        bus.IN_AXIS_TDATA  = '0;
        bus.IN_AXIS_TVALID = 1'b0;
        bus.IN_AXIS_TLAST  = 1'b0;

        // Test 1: contiguous block
        do_reset(5, 1'b1);
        chk("post_rst_tready", {63'd0, bus.IN_AXIS_TREADY}, 1);
        push_exp(64'd3, 1'b1, 32'd1, 32'd0);
        send_cnt(64'd10, 1'b0);
        send_cnt(64'd11, 1'b0);
        chk("t1_busy_mid", {63'd0, busy}, 1);
        send_cnt(64'd12, 1'b0);
        send_cnt(64'd13, 1'b0);
        chk("t1_done_now", {63'd0, done}, 1);
        chk("t1_busy_end", {63'd0, busy}, 0);
        idle(1);
        chk("t1_done_single", {63'd0, done}, 0);
        drain("t1_drain");

        // Test 2: TVALID gap inside a block
        do_reset(5, 1'b0);
        push_exp(64'd6, 1'b1, 32'd1, 32'd0);
        send_cnt(64'd10, 1'b0);
        send_cnt(64'd11, 1'b0);
        idle(3);
        send_cnt(64'd12, 1'b0);
        send_cnt(64'd13, 1'b1);
        drain("t2_drain");
        chk("t2_tlast_count", {32'd0, tlast_count}, 1);

        // Test 3: pattern errors
        do_reset(5, 1'b0);
        push_exp(64'd3, 1'b1, 32'd1, 32'd2);
        send_cnt(64'd10, 1'b0);
        send_cnt(64'd20, 1'b0);
        send_cnt(64'd20, 1'b0);
        send_cnt(64'd5, 1'b0);
        bad = {192'd0, 64'd30};
        bad[100] = 1'b1;
        send_beat(bad, 1'b0);
        chk("t3_upper_err", {32'd0, error_count}, 3);
        push_exp(64'd3, 1'b1, 32'd2, 32'd3);
        send_cnt(64'd31, 1'b0);
        send_cnt(64'd32, 1'b0);
        send_cnt(64'd33, 1'b0);
        drain("t3_drain");

        // Test 4: back-to-back blocks, no dead cycle
        do_reset(5, 1'b0);
        push_exp(64'd3, 1'b1, 32'd1, 32'd0);
        push_exp(64'd3, 1'b1, 32'd2, 32'd0);
        for (int i = 1; i <= 8; i++) send_cnt(64'(i), (i % 4) == 0);
        drain("t4_drain");
        chk("t4_done_pulses", done_times.size(), 2);
        if (done_times.size() == 2)
            chk("t4_done_spacing", 64'(done_times[1] - done_times[0]), 4);
        chk("t4_tlast_count", {32'd0, tlast_count}, 2);

        // Test 5: reset mid-block discards partial block and prev data
        do_reset(5, 1'b0);
        send_cnt(64'd50, 1'b1);
        send_cnt(64'd51, 1'b0);
        do_reset(3, 1'b1);
        push_exp(64'd3, 1'b1, 32'd1, 32'd0);
        for (int i = 1; i <= 4; i++) send_cnt(64'(i), 1'b0);
        drain("t5_drain");

        // Test 6: 1000 beats with TVALID held whenever possible
        do_reset(5, 1'b0);
        for (int b = 1; b <= 250; b++) begin
`ifdef QSFP_BW_THROTTLE_EN
            push_exp(64'd3, 1'b0, 32'(b), 32'd0);
`else
            push_exp(64'd3, 1'b1, 32'(b), 32'd0);
`endif
        end
        meas = 1'b1;
        for (int i = 0; i < 1000; i++) send_cnt(64'(1000 + i), 1'b0);
        meas = 1'b0;
        drain("t6_drain");
        chk("t6_block_count", {32'd0, block_count}, 250);
        chk("t6_error_count", {32'd0, error_count}, 0);
`ifdef QSFP_BW_THROTTLE_EN
        chk_range("t6_duty_pct", 64'((meas_rdy * 100) / meas_cyc), 70, 80);
`else
        chk("t6_ready_cycles", 64'(meas_rdy), 64'(meas_cyc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
